// File: rtl/seq_approx_mul.sv
// ----------------------------------------------------------------------------
// seq_approx_mul
//
// Iterative shift-add unsigned multiplier. One multiplier bit is handled per
// clock. An exact and a truncated (approximate) accumulator are built side by
// side so the approximation error is known exactly at the end of every
// operation. Results whose error exceeds ET are counted in a saturating
// violation counter.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. in_ready is high only in IDLE. out_valid is high only
// in DONE, and every out_* result stays constant until the transfer edge.
// There is no overlap between operations.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/ready   operand handshake; in_a, in_b, approx_en are sampled on it
//   out_valid/ready  result handshake
//   out_prod         approximate product if approx_en was set, else exact
//   out_err          exact product minus out_prod (never negative)
//   out_err_flag     out_err > ET
//   viol_cnt         saturating count of delivered results with the flag set
//   cnt_clr          synchronous clear of viol_cnt (wins over an increment)
//   dbg_state        current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ----------------------------------------------------------------------------
module seq_approx_mul #(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4,
  parameter int ET    = 7,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [2*WIDTH-1:0]   out_err,
  output logic                 out_err_flag,
  output logic [CNT_W-1:0]     viol_cnt,
  input  logic                 cnt_clr,
  output logic [1:0]           dbg_state
);

  localparam int PW    = 2 * WIDTH;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Columns kept by the approximate datapath. TRUNC >= PW keeps nothing.
  localparam logic [PW-1:0] KEEP_MASK = (TRUNC >= PW) ? '0 : ({PW{1'b1}} << TRUNC);
  localparam logic [PW-1:0] ET_V      = PW'(ET);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              appx_q;
  logic [PW-1:0]     exact_acc;
  logic [PW-1:0]     appx_acc;
  logic [IDX_W-1:0]  idx;

  logic [PW-1:0]     pp;
  logic [PW-1:0]     exact_nxt;
  logic [PW-1:0]     appx_nxt;
  logic [PW-1:0]     err_nxt;

  assign dbg_state = state;

  // Partial product of the current bit and the accumulator values after it.
  // The last RUN cycle loads the outputs straight from these so out_valid
  // rises on the same edge that the final bit is accumulated.
  always_comb begin
    pp = '0;
    if (b_q[idx]) pp = {{WIDTH{1'b0}}, a_q} << idx;
    exact_nxt = exact_acc + pp;
    appx_nxt  = appx_acc + (appx_q ? (pp & KEEP_MASK) : pp);
    // Approximate accumulation only ever drops bits, so this never wraps.
    err_nxt   = exact_nxt - appx_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_prod     <= '0;
      out_err      <= '0;
      out_err_flag <= 1'b0;
      viol_cnt     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      appx_q       <= 1'b0;
      exact_acc    <= '0;
      appx_acc     <= '0;
      idx          <= '0;
    end else begin
      // Counter sits beside the FSM; clear wins over a same-edge increment.
      if (cnt_clr) begin
        viol_cnt <= '0;
      end else if (out_valid && out_ready && out_err_flag && (viol_cnt != {CNT_W{1'b1}})) begin
        viol_cnt <= viol_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q       <= in_a;
            b_q       <= in_b;
            appx_q    <= approx_en;
            exact_acc <= '0;
            appx_acc  <= '0;
            idx       <= '0;
            in_ready  <= 1'b0;
            state     <= S_RUN;
          end
        end

        // Always WIDTH cycles, even for zero operands, so latency is fixed.
        S_RUN: begin
          exact_acc <= exact_nxt;
          appx_acc  <= appx_nxt;
          idx       <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            out_prod     <= appx_nxt;
            out_err      <= err_nxt;
            out_err_flag <= (err_nxt > ET_V);
            out_valid    <= 1'b1;
            state        <= S_DONE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_approx_mul.sv
// ----------------------------------------------------------------------------
// tb_seq_approx_mul
//
// Five builds of seq_approx_mul share one stimulus bus; each build has its own
// in_valid so only one operation is in flight at a time:
//   0: WIDTH=4 TRUNC=3 ET=7 CNT_W=16
//   1: defaults (WIDTH=8 TRUNC=4 ET=7 CNT_W=16)
//   2: WIDTH=4 TRUNC=3 ET=7 CNT_W=2
//   3: WIDTH=4 TRUNC=0
//   4: WIDTH=4 TRUNC=8 (everything truncated)
// Expected results are hand-computed constants pushed into exp_q at issue
// time; a monitor pops and compares on every output handshake.
// ----------------------------------------------------------------------------
module tb_seq_approx_mul;

  localparam int N = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           out_ready;
  logic           cnt_clr;
  logic           approx_en;
  logic [7:0]     in_a;
  logic [7:0]     in_b;
  logic [N-1:0]   iv;
  logic [N-1:0]   ir;
  logic [N-1:0]   ov;
  logic [N-1:0]   flag_m;
  logic [15:0]    prod_m [N];
  logic [15:0]    err_m  [N];
  logic [15:0]    cnt_m  [N];
  logic [1:0]     st_m   [N];

  logic [7:0]  p0, e0, p2, e2, p3, e3, p4, e4;
  logic [15:0] p1, e1;
  logic [15:0] c0, c1, c3, c4;
  logic [1:0]  c2;

  seq_approx_mul #(.WIDTH(4), .TRUNC(3), .ET(7), .CNT_W(16)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(in_a[3:0]), .in_b(in_b[3:0]),
    .approx_en(approx_en), .out_valid(ov[0]), .out_ready(out_ready), .out_prod(p0), .out_err(e0),
    .out_err_flag(flag_m[0]), .viol_cnt(c0), .cnt_clr(cnt_clr), .dbg_state(st_m[0]));

  seq_approx_mul u_def (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(in_a), .in_b(in_b),
    .approx_en(approx_en), .out_valid(ov[1]), .out_ready(out_ready), .out_prod(p1), .out_err(e1),
    .out_err_flag(flag_m[1]), .viol_cnt(c1), .cnt_clr(cnt_clr), .dbg_state(st_m[1]));

  seq_approx_mul #(.WIDTH(4), .TRUNC(3), .ET(7), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(in_a[3:0]), .in_b(in_b[3:0]),
    .approx_en(approx_en), .out_valid(ov[2]), .out_ready(out_ready), .out_prod(p2), .out_err(e2),
    .out_err_flag(flag_m[2]), .viol_cnt(c2), .cnt_clr(cnt_clr), .dbg_state(st_m[2]));

  seq_approx_mul #(.WIDTH(4), .TRUNC(0), .ET(7), .CNT_W(16)) u_t0 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_a(in_a[3:0]), .in_b(in_b[3:0]),
    .approx_en(approx_en), .out_valid(ov[3]), .out_ready(out_ready), .out_prod(p3), .out_err(e3),
    .out_err_flag(flag_m[3]), .viol_cnt(c3), .cnt_clr(cnt_clr), .dbg_state(st_m[3]));

  seq_approx_mul #(.WIDTH(4), .TRUNC(8), .ET(7), .CNT_W(16)) u_t8 (
    .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]), .in_a(in_a[3:0]), .in_b(in_b[3:0]),
    .approx_en(approx_en), .out_valid(ov[4]), .out_ready(out_ready), .out_prod(p4), .out_err(e4),
    .out_err_flag(flag_m[4]), .viol_cnt(c4), .cnt_clr(cnt_clr), .dbg_state(st_m[4]));

  assign prod_m[0] = {8'd0, p0};
  assign prod_m[1] = p1;
  assign prod_m[2] = {8'd0, p2};
  assign prod_m[3] = {8'd0, p3};
  assign prod_m[4] = {8'd0, p4};
  assign err_m[0]  = {8'd0, e0};
  assign err_m[1]  = e1;
  assign err_m[2]  = {8'd0, e2};
  assign err_m[3]  = {8'd0, e3};
  assign err_m[4]  = {8'd0, e4};
  assign cnt_m[0]  = c0;
  assign cnt_m[1]  = c1;
  assign cnt_m[2]  = {14'd0, c2};
  assign cnt_m[3]  = c3;
  assign cnt_m[4]  = c4;

  int wid  [N] = '{4, 8, 4, 4, 4};
  int cmax [N] = '{65535, 65535, 3, 65535, 65535};
  int exp_cnt [N];

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int fail_cnt  = 0;
  logic [32:0] exp_q[$];   // {prod[15:0], err[15:0], flag}
  logic [32:0] mon_e;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s inst%0d: got %0d, required %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (ov[k] && out_ready) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            fail_cnt++;
            $display("FAIL unexpected_output inst%0d: got out_valid=1, required no result", k);
          end else begin
            mon_e = exp_q.pop_front();
            check("out_prod", k, 32'(prod_m[k]), 32'(mon_e[32:17]));
            check("out_err", k, 32'(err_m[k]), 32'(mon_e[16:1]));
            check("out_err_flag", k, 32'(flag_m[k]), 32'(mon_e[0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+#1.
  task automatic issue(input int k, input int a, input int b, input bit ap,
                       input bit push, input int ep, input int ee, input bit ef);
    check("in_ready_idle", k, 32'(ir[k]), 1);
    if (push) exp_q.push_back({16'(ep), 16'(ee), ef});
    in_a = 8'(a);
    in_b = 8'(b);
    approx_en = ap;
    iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    // Scribble on the operand bus; the block must ignore it while busy.
    in_a = 8'hA5;
    in_b = 8'h5A;
    approx_en = ~ap;
    check("in_ready_busy", k, 32'(ir[k]), 0);
  endtask

  task automatic wait_valid(input int k);
    int cyc;
    cyc = 1;
    while (!ov[k] && cyc < 64) begin
      @(posedge clk); #1;
      if (!ov[k]) cyc++;
    end
    check("latency", k, 32'(cyc), 32'(wid[k]));
  endtask

  task automatic finish_op(input int k, input bit ef, input bit clr);
    int cyc;
    cnt_clr = clr;
    if (clr) exp_cnt[k] = 0;
    else if (ef && exp_cnt[k] < cmax[k]) exp_cnt[k]++;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    cyc = 0;
    while (ov[k] && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("valid_drop", k, 32'(ov[k]), 0);
    check("viol_cnt", k, 32'(cnt_m[k]), 32'(exp_cnt[k]));
    check("in_ready_back", k, 32'(ir[k]), 1);
  endtask

  task automatic op(input int k, input int a, input int b, input bit ap,
                    input int ep, input int ee, input bit ef);
    issue(k, a, b, ap, 1'b1, ep, ee, ef);
    wait_valid(k);
    finish_op(k, ef, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    iv = '0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    in_a = '0;
    in_b = '0;
    approx_en = 1'b0;
    for (int k = 0; k < N; k++) exp_cnt[k] = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      check("rst_in_ready", k, 32'(ir[k]), 1);
      check("rst_out_valid", k, 32'(ov[k]), 0);
      check("rst_out_prod", k, 32'(prod_m[k]), 0);
      check("rst_out_err", k, 32'(err_m[k]), 0);
      check("rst_flag", k, 32'(flag_m[k]), 0);
      check("rst_viol_cnt", k, 32'(cnt_m[k]), 0);
      check("rst_state", k, 32'(st_m[k]), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // WIDTH=4, TRUNC=3: flagged, exact, and err exactly at ET.
    op(0, 15, 15, 1'b1, 208, 17, 1'b1);
    op(0, 7, 15, 1'b0, 105, 0, 1'b0);
    op(0, 1, 15, 1'b1, 8, 7, 1'b0);

    // Back-pressure: outputs must hold while out_ready is low.
    out_ready = 1'b0;
    issue(0, 3, 3, 1'b1, 1'b1, 0, 9, 1'b1);
    wait_valid(0);
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_valid", 0, 32'(ov[0]), 1);
      check("hold_prod", 0, 32'(prod_m[0]), 0);
      check("hold_err", 0, 32'(err_m[0]), 9);
      check("hold_flag", 0, 32'(flag_m[0]), 1);
      check("hold_in_ready", 0, 32'(ir[0]), 0);
      check("hold_viol_cnt", 0, 32'(cnt_m[0]), 32'(exp_cnt[0]));
      check("hold_state", 0, 32'(st_m[0]), 2);
    end
    out_ready = 1'b1;
    finish_op(0, 1'b1, 1'b0);

    // Defaults: zero operand still takes 8 cycles; full-scale truncation.
    op(1, 0, 255, 1'b1, 0, 0, 1'b0);
    op(1, 255, 255, 1'b1, 64976, 49, 1'b1);
    op(1, 200, 100, 1'b0, 20000, 0, 1'b0);

    // TRUNC boundaries.
    op(3, 15, 15, 1'b1, 225, 0, 1'b0);
    op(4, 15, 15, 1'b1, 0, 225, 1'b1);
    op(4, 13, 11, 1'b0, 143, 0, 1'b0);

    // Reset in the middle of RUN: no result may come out.
    issue(0, 15, 15, 1'b1, 1'b0, 0, 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) exp_cnt[k] = 0;
    check("abort_in_ready", 0, 32'(ir[0]), 1);
    check("abort_out_valid", 0, 32'(ov[0]), 0);
    check("abort_viol_cnt", 0, 32'(cnt_m[0]), 0);
    check("abort_state", 0, 32'(st_m[0]), 0);
    repeat (6) @(posedge clk);
    #1;
    op(0, 5, 9, 1'b1, 40, 5, 1'b0);

    // CNT_W=2: saturation, then clear racing a flagged handshake.
    repeat (5) op(2, 15, 15, 1'b1, 208, 17, 1'b1);
    issue(2, 15, 15, 1'b1, 1'b1, 208, 17, 1'b1);
    wait_valid(2);
    finish_op(2, 1'b1, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", 0, 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

  initial begin
    #100000;
    fail_cnt++;
    $display("FAIL watchdog: got no completion by %0t, required completion", $time);
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
